// File: rtl/runway_scheduler.sv
// runway_scheduler: queues landing and takeoff requests in two FIFOs and
// grants the single runway to one aircraft at a time. Weather state gates
// which request types may be granted, stretches occupancy under CAUTION,
// and flushes departures under EMERGENCY.
module runway_scheduler #(
    parameter int QUEUE_DEPTH = 4,
    parameter int ID_W        = 4,
    parameter int OCC_CYCLES  = 5
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [1:0]                   ECSU_state,
    input  logic                         arr_req,
    input  logic [ID_W-1:0]              arr_id,
    input  logic                         dep_req,
    input  logic [ID_W-1:0]              dep_id,
    output logic [$clog2(QUEUE_DEPTH):0] arr_count,
    output logic [$clog2(QUEUE_DEPTH):0] dep_count,
    output logic                         arr_full,
    output logic                         dep_full,
    output logic                         arr_drop,
    output logic                         dep_drop,
    output logic                         grant_valid,
    output logic [ID_W-1:0]              grant_id,
    output logic                         grant_is_arrival,
    output logic                         runway_busy,
    output logic [1:0]                   sched_state
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = $clog2(2 * OCC_CYCLES);
    localparam logic [OCC_W-1:0] OCC_LOAD     = OCC_W'(OCC_CYCLES - 1);
    localparam logic [OCC_W-1:0] CAUTION_LOAD = OCC_W'(2 * OCC_CYCLES - 1);

    localparam logic [1:0] WX_ALL_CLEAR  = 2'b00;
    localparam logic [1:0] WX_CAUTION    = 2'b01;
    localparam logic [1:0] WX_EMERGENCY  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LANDING = 2'b01,
        ST_TAKEOFF = 2'b10
    } sched_state_t;

    // Index 0 is the arrival FIFO, index 1 the departure FIFO.
    logic [1:0]       push_req;
    logic [1:0]       pop;
    logic [1:0]       flush;
    logic [1:0]       fifo_full;
    logic [1:0]       fifo_empty;
    logic [1:0]       fifo_drop;
    logic [ID_W-1:0]  push_id    [2];
    logic [ID_W-1:0]  head_id    [2];
    logic [CNT_W-1:0] fifo_count [2];

    logic emergency;
    logic caution;
    logic dep_allowed;

    sched_state_t     state_reg, state_next;
    logic [OCC_W-1:0] occ_reg;
    logic [1:0]       land_streak_reg;
    logic             grant_arr, grant_dep;
    logic             grant_valid_reg;
    logic [ID_W-1:0]  grant_id_reg;
    logic             grant_is_arrival_reg;

    assign emergency   = (ECSU_state == WX_EMERGENCY);
    assign caution     = (ECSU_state == WX_CAUTION);
    assign dep_allowed = (ECSU_state == WX_ALL_CLEAR) || caution;

    assign push_req   = {dep_req, arr_req};
    assign push_id[0] = arr_id;
    assign push_id[1] = dep_id;
    assign flush      = {emergency, 1'b0};
    assign pop        = {grant_dep, grant_arr};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : fifo_g
            logic [ID_W-1:0]  mem [QUEUE_DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             drop_reg;
            logic             full;
            logic             accept;

            assign full   = (cnt_reg == CNT_W'(QUEUE_DEPTH));
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            assign accept = push_req[gi] && !flush[gi] && (!full || pop[gi]);

            // Storage array: written on accepted pushes only.
            always_ff @(posedge CLK) begin
                if (accept) begin
                    mem[wr_ptr_reg] <= push_id[gi];
                end
            end

            // Pointer, occupancy and drop-pulse bookkeeping.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                    drop_reg   <= 1'b0;
                end else if (flush[gi]) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                    drop_reg   <= push_req[gi];
                end else begin
                    drop_reg <= push_req[gi] && !accept;
                    if (accept) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    case ({accept, pop[gi]})
                        2'b10:   cnt_reg <= cnt_reg + 1'b1;
                        2'b01:   cnt_reg <= cnt_reg - 1'b1;
                        default: cnt_reg <= cnt_reg;
                    endcase
                end
            end

            assign head_id[gi]    = mem[rd_ptr_reg];
            assign fifo_count[gi] = cnt_reg;
            assign fifo_full[gi]  = full;
            assign fifo_empty[gi] = (cnt_reg == '0);
            assign fifo_drop[gi]  = drop_reg;
        end
    endgenerate

    // Runway state register and occupancy countdown.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
            occ_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_arr || grant_dep) begin
                occ_reg <= caution ? CAUTION_LOAD : OCC_LOAD;
            end else if (state_reg != ST_IDLE && occ_reg != '0) begin
                occ_reg <= occ_reg - OCC_W'(1);
            end
        end
    end

    // Grant selection in IDLE (takeoff first once two landings have gone),
    // and return to IDLE when the countdown reaches zero.
    always_comb begin
        state_next = state_reg;
        grant_arr  = 1'b0;
        grant_dep  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (dep_allowed && !fifo_empty[1] && land_streak_reg >= 2'd2) begin
                    grant_dep = 1'b1;
                end else if (!fifo_empty[0]) begin
                    grant_arr = 1'b1;
                end else if (dep_allowed && !fifo_empty[1]) begin
                    grant_dep = 1'b1;
                end
                if (grant_arr) begin
                    state_next = ST_LANDING;
                end else if (grant_dep) begin
                    state_next = ST_TAKEOFF;
                end
            end
            ST_LANDING, ST_TAKEOFF: begin
                if (occ_reg == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Landing streak for fairness, and the registered grant outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            land_streak_reg      <= 2'd0;
            grant_valid_reg      <= 1'b0;
            grant_id_reg         <= '0;
            grant_is_arrival_reg <= 1'b0;
        end else begin
            if (emergency || grant_dep) begin
                land_streak_reg <= 2'd0;
            end else if (grant_arr && land_streak_reg != 2'd3) begin
                land_streak_reg <= land_streak_reg + 2'd1;
            end
            grant_valid_reg <= grant_arr || grant_dep;
            if (grant_arr) begin
                grant_id_reg         <= head_id[0];
                grant_is_arrival_reg <= 1'b1;
            end else if (grant_dep) begin
                grant_id_reg         <= head_id[1];
                grant_is_arrival_reg <= 1'b0;
            end
        end
    end

    assign arr_count        = fifo_count[0];
    assign dep_count        = fifo_count[1];
    assign arr_full         = fifo_full[0];
    assign dep_full         = fifo_full[1];
    assign arr_drop         = fifo_drop[0];
    assign dep_drop         = fifo_drop[1];
    assign grant_valid      = grant_valid_reg;
    assign grant_id         = grant_id_reg;
    assign grant_is_arrival = grant_is_arrival_reg;
    assign runway_busy      = (state_reg != ST_IDLE);
    assign sched_state      = state_reg;

endmodule

// File: tb/tb_runway_scheduler.sv
// Directed self-checking bench for runway_scheduler (QUEUE_DEPTH=4, ID_W=4,
// OCC_CYCLES=5). Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point; grants are logged on the
// falling edge.
module tb_runway_scheduler;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] ECSU_state = 2'b00;
    logic       arr_req = 1'b0;
    logic [3:0] arr_id = 4'd0;
    logic       dep_req = 1'b0;
    logic [3:0] dep_id = 4'd0;
    logic [2:0] arr_count;
    logic [2:0] dep_count;
    logic       arr_full;
    logic       dep_full;
    logic       arr_drop;
    logic       dep_drop;
    logic       grant_valid;
    logic [3:0] grant_id;
    logic       grant_is_arrival;
    logic       runway_busy;
    logic [1:0] sched_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_n;
    int g_id  [$];
    int g_arr [$];
    int g_cyc [$];

    runway_scheduler #(
        .QUEUE_DEPTH(4),
        .ID_W(4),
        .OCC_CYCLES(5)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .ECSU_state(ECSU_state),
        .arr_req(arr_req),
        .arr_id(arr_id),
        .dep_req(dep_req),
        .dep_id(dep_id),
        .arr_count(arr_count),
        .dep_count(dep_count),
        .arr_full(arr_full),
        .dep_full(dep_full),
        .arr_drop(arr_drop),
        .dep_drop(dep_drop),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .grant_is_arrival(grant_is_arrival),
        .runway_busy(runway_busy),
        .sched_state(sched_state)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Grant log: one line per grant.
    always @(negedge CLK) begin
        if (grant_valid) begin
            g_id.push_back(int'(grant_id));
            g_arr.push_back(int'(grant_is_arrival));
            g_cyc.push_back(cyc);
            $display("grant cyc=%0d id=%0d arrival=%0d", cyc, grant_id, grant_is_arrival);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        arr_req = 1'b0;
        dep_req = 1'b0;
        ECSU_state = 2'b00;
        tick();
        tick();
        RST_N = 1'b1;
        g_id.delete();
        g_arr.delete();
        g_cyc.delete();
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (runway_busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(runway_busy), 32'd0);
        check("rst_arr_count", 32'(arr_count), 32'd0);
        check("rst_dep_count", 32'(dep_count), 32'd0);
        check("rst_state", 32'(sched_state), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        RST_N = 1'b1;
        tick();

        // Basic landing: ID 3, grant two cycles after the push cycle, busy 5
        arr_req = 1'b1; arr_id = 4'd3;
        tick();
        arr_req = 1'b0;
        check("land_count_after_push", 32'(arr_count), 32'd1);
        check("land_no_early_grant", 32'(grant_valid), 32'd0);
        tick();
        check("land_grant_valid", 32'(grant_valid), 32'd1);
        check("land_grant_id", 32'(grant_id), 32'd3);
        check("land_is_arrival", 32'(grant_is_arrival), 32'd1);
        check("land_state", 32'(sched_state), 32'd1);
        check("land_count_popped", 32'(arr_count), 32'd0);
        measure_busy(busy_n);
        check("land_busy_cycles", 32'(busy_n), 32'd5);
        check("land_back_idle", 32'(sched_state), 32'd0);
        check("land_id_held", 32'(grant_id), 32'd3);

        // Fairness: arrivals 1,2,4 and departure 9 -> order 1,2,9,4, spacing 6
        do_reset();
        arr_req = 1'b1; arr_id = 4'd1; dep_req = 1'b1; dep_id = 4'd9;
        tick();
        dep_req = 1'b0; arr_id = 4'd2;
        tick();
        arr_id = 4'd4;
        tick();
        arr_req = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("fair_grant_count", 32'(g_id.size()), 32'd4);
        if (g_id.size() == 4) begin
            check("fair_id0", 32'(g_id[0]), 32'd1);
            check("fair_id1", 32'(g_id[1]), 32'd2);
            check("fair_id2", 32'(g_id[2]), 32'd9);
            check("fair_id3", 32'(g_id[3]), 32'd4);
            check("fair_type2", 32'(g_arr[2]), 32'd0);
            check("fair_type3", 32'(g_arr[3]), 32'd1);
            for (int i = 1; i < 4; i++) begin
                check("fair_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd6);
            end
        end

        // Weather gating: HIGH_ALERT blocks takeoff; CAUTION grants it, busy 10
        do_reset();
        ECSU_state = 2'b10;
        dep_req = 1'b1; dep_id = 4'd5;
        tick();
        dep_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("ha_no_grant", 32'(g_id.size()), 32'd0);
        check("ha_dep_count", 32'(dep_count), 32'd1);
        check("ha_idle", 32'(runway_busy), 32'd0);
        ECSU_state = 2'b01;
        tick();
        check("caut_grant_valid", 32'(grant_valid), 32'd1);
        check("caut_grant_id", 32'(grant_id), 32'd5);
        check("caut_is_arrival", 32'(grant_is_arrival), 32'd0);
        check("caut_state", 32'(sched_state), 32'd2);
        check("caut_dep_count", 32'(dep_count), 32'd0);
        measure_busy(busy_n);
        check("caut_busy_cycles", 32'(busy_n), 32'd10);

        // EMERGENCY flush, dep drop, arrival still granted
        do_reset();
        ECSU_state = 2'b10;
        dep_req = 1'b1; dep_id = 4'd7;
        tick();
        dep_id = 4'd8;
        tick();
        dep_req = 1'b0;
        check("em_dep_queued", 32'(dep_count), 32'd2);
        ECSU_state = 2'b11;
        arr_req = 1'b1; arr_id = 4'd6;
        tick();
        arr_req = 1'b0;
        check("em_flushed", 32'(dep_count), 32'd0);
        check("em_arr_count", 32'(arr_count), 32'd1);
        dep_req = 1'b1; dep_id = 4'd10;
        tick();
        dep_req = 1'b0;
        check("em_dep_drop", 32'(dep_drop), 32'd1);
        check("em_dep_count", 32'(dep_count), 32'd0);
        check("em_arr_grant", 32'(grant_valid), 32'd1);
        check("em_arr_grant_id", 32'(grant_id), 32'd6);
        tick();
        check("em_drop_pulse_end", 32'(dep_drop), 32'd0);

        // Full arrival FIFO: 5th push while busy drops; push with pop does not
        do_reset();
        arr_req = 1'b1; arr_id = 4'd1;
        tick();
        arr_req = 1'b0;
        tick();
        check("full_first_grant", 32'(grant_id), 32'd1);
        for (int i = 2; i <= 5; i++) begin
            arr_req = 1'b1; arr_id = 4'(i);
            tick();
        end
        check("full_count4", 32'(arr_count), 32'd4);
        check("full_flag", 32'(arr_full), 32'd1);
        check("full_no_drop_yet", 32'(arr_drop), 32'd0);
        arr_id = 4'd6;
        tick();
        check("full_drop", 32'(arr_drop), 32'd1);
        check("full_count_after_drop", 32'(arr_count), 32'd4);
        arr_id = 4'd7;
        tick();
        arr_req = 1'b0;
        check("full_pushpop_no_drop", 32'(arr_drop), 32'd0);
        check("full_pushpop_count", 32'(arr_count), 32'd4);
        check("full_pushpop_grant", 32'(grant_valid), 32'd1);
        check("full_pushpop_id", 32'(grant_id), 32'd2);

        // Reset mid-operation (3rd busy cycle), checked asynchronously
        tick();
        tick();
        check("mid_busy_before", 32'(runway_busy), 32'd1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_busy", 32'(runway_busy), 32'd0);
        check("mid_rst_arr_count", 32'(arr_count), 32'd0);
        check("mid_rst_dep_count", 32'(dep_count), 32'd0);
        check("mid_rst_state", 32'(sched_state), 32'd0);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        tick();
        RST_N = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/runway_scheduler.md
# runway_scheduler

Runway access scheduler driven by the weather/emergency state unit. It queues landing (arrival) and takeoff (departure) requests in two FIFOs and grants the single runway to one aircraft at a time. Each grant holds the runway for a fixed occupancy time. Which request types may be granted depends on the current `ECSU_state` value (ALL_CLEAR/CAUTION/HIGH_ALERT/EMERGENCY). It sits beside the weather unit and feeds the tower display and the aircraft-ID bus.

## Interface
- `QUEUE_DEPTH`, default 4: entries per FIFO; must be a power of 2 and at least 2.
- `ID_W`, default 4: aircraft ID width.
- `OCC_CYCLES`, default 5: runway occupancy per operation in clear weather; must be at least 2.
- `CLK`, input, 1: single clock, rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `ECSU_state`, input, 2: weather state (00 ALL_CLEAR, 01 CAUTION, 10 HIGH_ALERT, 11 EMERGENCY).
- `arr_req`, input, 1: push `arr_id` into the arrival FIFO this cycle.
- `arr_id`, input, ID_W: arriving aircraft ID.
- `dep_req`, input, 1: push `dep_id` into the departure FIFO this cycle.
- `dep_id`, input, ID_W: departing aircraft ID.
- `arr_count` / `dep_count`, output, clog2(QUEUE_DEPTH)+1: FIFO occupancy.
- `arr_full` / `dep_full`, output, 1: count equals QUEUE_DEPTH.
- `arr_drop` / `dep_drop`, output, 1: one-cycle pulse when a push was rejected.
- `grant_valid`, output, 1: one-cycle pulse when the runway is granted.
- `grant_id`, output, ID_W: granted aircraft ID; holds its value until the next grant.
- `grant_is_arrival`, output, 1: 1 means landing, 0 means takeoff; holds like `grant_id`.
- `runway_busy`, output, 1: runway occupied.
- `sched_state`, output, 2: 00 IDLE, 01 LANDING, 10 TAKEOFF.

## Operation
- FIFOs:
  - Registered, in-order.
  - A push and a pop in the same cycle are legal. The count is unchanged, even when the FIFO is full.
  - A push to a full FIFO is discarded and pulses the matching `*_drop` flag, unless a pop happens in the same cycle.
- Permission by `ECSU_state`, sampled only in IDLE:
  - ALL_CLEAR and CAUTION: landings and takeoffs allowed.
  - HIGH_ALERT: landings only.
  - EMERGENCY: landings only. Every cycle, the departure FIFO is flushed to empty, and any `dep_req` is discarded with a `dep_drop` pulse.
- Selection in IDLE, evaluated in this order:
  1. If takeoffs are allowed, the departure FIFO is non-empty, and `land_streak` is at least 2, grant a takeoff.
  2. Else if the arrival FIFO is non-empty, grant a landing.
  3. Else if takeoffs are allowed and the departure FIFO is non-empty, grant a takeoff.
  4. Else stay in IDLE.
- `land_streak` (2-bit, saturating at 3):
  - Increments on each landing grant.
  - Clears on each takeoff grant.
  - Is held at 0 while `ECSU_state` is EMERGENCY.
- On a grant:
  - Pop the head of the chosen FIFO.
  - Register its ID into `grant_id` and the type into `grant_is_arrival`.
  - Move to LANDING or TAKEOFF.
  - Load the occupancy counter with OCC_CYCLES-1, or 2*OCC_CYCLES-1 if `ECSU_state` is CAUTION at grant time.
- In LANDING or TAKEOFF:
  - The counter decrements each cycle.
  - On the edge where it reads 0, the block returns to IDLE.
  - `ECSU_state` changes mid-operation do not abort or extend the operation.
  - An EMERGENCY flush still applies to the departure FIFO during the operation.
- `runway_busy` is 1 exactly when `sched_state` is not IDLE.
- Reset (asynchronous, any time):
  - Both FIFOs are emptied.
  - `sched_state` is IDLE and the counter is 0.
  - `land_streak` is 0.
  - All outputs are 0, including `grant_id` and `grant_is_arrival`.

## Timing
- Push: `*_count` and `*_full` update on the edge that samples `*_req`. A drop pulse appears in the cycle after that edge.
- Grant decision: made combinationally in an IDLE cycle.
- First cycle of a granted operation (the edge after the IDLE decision cycle):
  - `grant_valid` is high for this one cycle.
  - `runway_busy` is high.
  - `sched_state` shows LANDING or TAKEOFF.
  - The FIFO count has already decremented.
- Busy duration: `runway_busy` stays high for exactly OCC_CYCLES cycles, or 2*OCC_CYCLES under CAUTION, counting the grant cycle.
- Grant spacing: back-to-back grants are at least OCC_CYCLES+1 cycles apart, because at least one IDLE cycle separates operations.
- Latency: a request pushed into an empty FIFO while the runway is IDLE is granted two cycles after `*_req` is sampled.
- Weather input: `ECSU_state` is used unregistered. It affects only the IDLE decision, the CAUTION occupancy load, and the EMERGENCY flush/drop behaviour.

## Test plan
- Basic landing: after reset, push arrival ID 3 in ALL_CLEAR with OCC_CYCLES=5. Expect `grant_valid` two cycles later with `grant_id`=3 and `grant_is_arrival`=1, `runway_busy` high for 5 cycles, then IDLE.
- Fairness: queue arrivals 1, 2, 4 and departure 9. Expect grant order 1, 2, 9, 4, with consecutive grants 6 cycles apart.
- Weather gating and CAUTION occupancy:
  - In HIGH_ALERT, push departure 5. No grant occurs and `dep_count` stays 1.
  - Switch to CAUTION. Departure 5 is granted and busy lasts 10 cycles.
- EMERGENCY flush: with 2 departures queued, drive EMERGENCY.
  - Next edge: `dep_count` is 0.
  - A `dep_req` in EMERGENCY gives a `dep_drop` pulse.
  - An arrival queued in the same cycle is still granted.
- Full FIFO: with QUEUE_DEPTH=4, push 5 arrivals while busy. The 5th gets an `arr_drop` pulse and `arr_count` is 4. Push simultaneously with a grant pop: no drop, and the count stays 4.
- Reset mid-operation: assert `RST_N` low in the 3rd busy cycle. Immediately (asynchronously) expect `runway_busy`=0, both counts 0, and `sched_state`=IDLE.
